// File: rtl/tlul_pkg.sv
// TL-UL error monitor shared definitions.
// Opcodes, violation class bit indices and widths.
package tlul_pkg;

  localparam int ErrClassW = 7;

  localparam logic [2:0] OpPutFull = 3'd0;
  localparam logic [2:0] OpPutPart = 3'd1;
  localparam logic [2:0] OpGet     = 3'd4;

  typedef enum logic [2:0] {
    ErrBadOp  = 3'd0,
    ErrSize   = 3'd1,
    ErrAlign  = 3'd2,
    ErrMask   = 3'd3,
    ErrFull   = 3'd4,
    ErrDUnexp = 3'd5,
    ErrOvf    = 3'd6
  } err_class_e;

endpackage

// File: rtl/tlul_err_mon_if.sv
// Observed TL-UL A/D channel bundle.
// The monitor only ever takes the slave view.
interface tlul_err_mon_if #(
  parameter int DW  = 64,
  parameter int AW  = 32,
  parameter int SZW = 3,
  parameter int IW  = 8
) ();
  logic            a_valid_i;
  logic            a_ready_i;
  logic [2:0]      a_opcode_i;
  logic [SZW-1:0]  a_size_i;
  logic [AW-1:0]   a_address_i;
  logic [DW/8-1:0] a_mask_i;
  logic [IW-1:0]   a_source_i;
  logic            d_valid_i;
  logic            d_ready_i;

  modport master (
    output a_valid_i, a_ready_i, a_opcode_i,
    output a_size_i, a_address_i, a_mask_i,
    output a_source_i, d_valid_i, d_ready_i
  );

  modport slave (
    input a_valid_i, a_ready_i, a_opcode_i,
    input a_size_i, a_address_i, a_mask_i,
    input a_source_i, d_valid_i, d_ready_i
  );
endinterface

// File: rtl/tlul_err_lane_chk.sv
// Combinational A-channel legality check.
// Yields class bits [4:0] from opcode/size/address/mask.
module tlul_err_lane_chk
  import tlul_pkg::*;
#(
  parameter int DW  = 64,
  parameter int SZW = 3,
  parameter int AW  = 32
) (
  input  logic [2:0]      opcode_i,
  input  logic [SZW-1:0]  size_i,
  input  logic [AW-1:0]   addr_i,
  input  logic [DW/8-1:0] mask_i,
  output logic [4:0]      cls_o
);
  localparam int NB    = DW / 8;
  localparam int SubAW = $clog2(NB);

  logic             size_err;
  logic [SubAW-1:0] off;
  logic [SubAW-1:0] lo_mask;
  logic [NB-1:0]    win;
  logic             unused_addr;

  assign unused_addr = ^addr_i[AW-1:SubAW];

  // A lane is in the window when it shares the
  // request's offset above the low size bits.
  always_comb begin
    size_err = size_i > SZW'(SubAW);
    off      = addr_i[SubAW-1:0];
    lo_mask  = '0;
    for (int i = 0; i < SubAW; i++) begin
      lo_mask[i] = i < int'(size_i);
    end
    win = '0;
    for (int j = 0; j < NB; j++) begin
      win[j] = ((SubAW'(j) ^ off) & ~lo_mask) == '0;
    end
    cls_o = '0;
    cls_o[ErrBadOp] = !(opcode_i inside
      {OpPutFull, OpPutPart, OpGet});
    if (size_err) begin
      cls_o[ErrSize] = 1'b1;
    end else begin
      cls_o[ErrAlign] = |(off & lo_mask);
      cls_o[ErrMask]  = |(mask_i & ~win);
      cls_o[ErrFull]  = (opcode_i == OpPutFull)
                      & |(~mask_i & win);
    end
  end
endmodule

// File: rtl/tlul_err_mon.sv
// Passive TL-UL error monitor: pulse, sticky, count, capture.
// Capture regs exist only with TLUL_ERR_CAPTURE_EN defined.
module tlul_err_mon
  import tlul_pkg::*;
#(
  parameter int DW             = 64,
  parameter int AW             = 32,
  parameter int SZW            = 3,
  parameter int IW             = 8,
  parameter int MaxOutstanding = 4,
  parameter int CW             = 16,
  localparam int OW = $clog2(MaxOutstanding + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  tlul_err_mon_if.slave        bus,
  input  logic                 clr_i,
  output logic                 err_comb_o,
  output logic                 err_o,
  output logic [ErrClassW-1:0] err_class_o,
  output logic [CW-1:0]        err_cnt_o,
  output logic [OW-1:0]        outstanding_o,
  output logic                 cap_valid_o,
  output logic [ErrClassW-1:0] cap_class_o,
  output logic [AW-1:0]        cap_addr_o,
  output logic [IW-1:0]        cap_source_o,
  output logic [2:0]           cap_opcode_o,
  output logic [SZW-1:0]       cap_size_o
);
  if (!(DW == 32 || DW == 64 || DW == 128)) begin : g_bad_dw
    $error("tlul_err_mon: DW must be 32, 64 or 128");
  end
  if (MaxOutstanding < 1) begin : g_bad_max
    $error("tlul_err_mon: MaxOutstanding must be >= 1");
  end

  logic                 a_fire;
  logic                 d_fire;
  logic [4:0]           cls_a;
  logic                 d_unexp;
  logic                 ovf;
  logic                 a_err;
  logic                 ev;
  logic [ErrClassW-1:0] ev_cls;
  logic [OW-1:0]        out_d;

  assign a_fire = bus.a_valid_i & bus.a_ready_i;
  assign d_fire = bus.d_valid_i & bus.d_ready_i;

  tlul_err_lane_chk #(
    .DW  (DW),
    .SZW (SZW),
    .AW  (AW)
  ) u_chk (
    .opcode_i (bus.a_opcode_i),
    .size_i   (bus.a_size_i),
    .addr_i   (bus.a_address_i),
    .mask_i   (bus.a_mask_i),
    .cls_o    (cls_a)
  );

  assign err_comb_o = bus.a_valid_i & |cls_a;

  // Classify the cycle and compute next outstanding count.
  always_comb begin
    d_unexp = d_fire & (outstanding_o == '0);
    ovf     = a_fire & ~d_fire
            & (outstanding_o == OW'(MaxOutstanding));
    a_err   = a_fire & |cls_a;
    ev_cls  = {ovf, d_unexp, (a_err ? cls_a : 5'b0)};
    ev      = |ev_cls;
    out_d   = outstanding_o;
    if (a_fire & ~ovf & ~(d_fire & ~d_unexp)) begin
      out_d = outstanding_o + 1'b1;
    end else if (~a_fire & d_fire & ~d_unexp) begin
      out_d = outstanding_o - 1'b1;
    end
  end

  // Outstanding tracker; clr leaves it alone.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstanding_o <= '0;
    end else begin
      outstanding_o <= out_d;
    end
  end

  // Pulse, sticky classes and saturating counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_o       <= 1'b0;
      err_class_o <= '0;
      err_cnt_o   <= '0;
    end else begin
      err_o <= ev;
      if (ev && clr_i) begin
        err_class_o <= ev_cls;
        err_cnt_o   <= CW'(1);
      end else if (ev) begin
        err_class_o <= err_class_o | ev_cls;
        if (err_cnt_o != '1) begin
          err_cnt_o <= err_cnt_o + 1'b1;
        end
      end else if (clr_i) begin
        err_class_o <= '0;
        err_cnt_o   <= '0;
      end
    end
  end

`ifdef TLUL_ERR_CAPTURE_EN
  logic a_cap;

  assign a_cap = a_fire & (|cls_a | ovf);

  // First-error capture; D-only events keep A fields at 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cap_valid_o  <= 1'b0;
      cap_class_o  <= '0;
      cap_addr_o   <= '0;
      cap_source_o <= '0;
      cap_opcode_o <= '0;
      cap_size_o   <= '0;
    end else if (ev && (!cap_valid_o || clr_i)) begin
      cap_valid_o  <= 1'b1;
      cap_class_o  <= ev_cls;
      cap_addr_o   <= a_cap ? bus.a_address_i : '0;
      cap_source_o <= a_cap ? bus.a_source_i : '0;
      cap_opcode_o <= a_cap ? bus.a_opcode_i : '0;
      cap_size_o   <= a_cap ? bus.a_size_i : '0;
    end else if (clr_i) begin
      cap_valid_o  <= 1'b0;
      cap_class_o  <= '0;
      cap_addr_o   <= '0;
      cap_source_o <= '0;
      cap_opcode_o <= '0;
      cap_size_o   <= '0;
    end
  end
`else
  logic unused_cap;

  assign unused_cap   = ^{bus.a_source_i, bus.a_address_i};
  assign cap_valid_o  = 1'b0;
  assign cap_class_o  = '0;
  assign cap_addr_o   = '0;
  assign cap_source_o = '0;
  assign cap_opcode_o = '0;
  assign cap_size_o   = '0;
`endif
endmodule

// File: tb/tb_tlul_err_mon.sv
// Self-checking bench for tlul_err_mon (DW=64, Max=4, CW=4).
// Works with and without TLUL_ERR_CAPTURE_EN.
module tb_tlul_err_mon;
  localparam int DW   = 64;
  localparam int AW   = 32;
  localparam int SZW  = 3;
  localparam int IW   = 8;
  localparam int MAXO = 4;
  localparam int CW   = 4;
  localparam int OW   = $clog2(MAXO + 1);
  localparam int CMAX = (1 << CW) - 1;
`ifdef TLUL_ERR_CAPTURE_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;

  logic          err_comb, err;
  logic [6:0]    err_class;
  logic [CW-1:0] err_cnt;
  logic [OW-1:0] outs;
  logic          cap_valid;
  logic [6:0]    cap_class;
  logic [AW-1:0] cap_addr;
  logic [IW-1:0] cap_source;
  logic [2:0]    cap_opcode;
  logic [SZW-1:0] cap_size;

  int n_cmp = 0;
  int n_bad = 0;

  tlul_err_mon_if #(.DW(DW), .AW(AW), .SZW(SZW), .IW(IW)) bus ();

  tlul_err_mon #(
    .DW(DW), .AW(AW), .SZW(SZW), .IW(IW),
    .MaxOutstanding(MAXO), .CW(CW)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .bus          (bus),
    .clr_i        (clr),
    .err_comb_o   (err_comb),
    .err_o        (err),
    .err_class_o  (err_class),
    .err_cnt_o    (err_cnt),
    .outstanding_o(outs),
    .cap_valid_o  (cap_valid),
    .cap_class_o  (cap_class),
    .cap_addr_o   (cap_addr),
    .cap_source_o (cap_source),
    .cap_opcode_o (cap_opcode),
    .cap_size_o   (cap_size)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Spec-level classification with byte arithmetic.
  function automatic int m_cls(int op, int sz, int addr, int mask);
    int c, nb, base, win;
    c = 0;
    if (!(op == 0 || op == 1 || op == 4)) c |= 1;
    if (sz > 3) begin
      c |= 2;
    end else begin
      nb   = 1 << sz;
      base = ((addr % 8) / nb) * nb;
      win  = (((1 << nb) - 1) << base) & 'hFF;
      if ((addr % nb) != 0) c |= 4;
      if ((mask & ~win & 'hFF) != 0) c |= 8;
      if (op == 0 && (mask & win) != win) c |= 16;
    end
    return c;
  endfunction

  int m_out, m_sticky, m_cnt, m_ccls, m_caddr, m_csrc, m_cop, m_csz;
  bit m_err, m_cv;

  // Reference model of the registered outputs.
  always @(posedge clk or negedge rst_n) begin : mdl
    int ac, ev;
    bit af, df, du, ov;
    if (!rst_n) begin
      m_out = 0; m_sticky = 0; m_cnt = 0; m_err = 0;
      m_cv = 0; m_ccls = 0; m_caddr = 0; m_csrc = 0;
      m_cop = 0; m_csz = 0;
    end else begin
      af = bus.a_valid_i && bus.a_ready_i;
      df = bus.d_valid_i && bus.d_ready_i;
      ac = af ? m_cls(int'(bus.a_opcode_i), int'(bus.a_size_i),
                      int'(bus.a_address_i), int'(bus.a_mask_i)) : 0;
      du = df && m_out == 0;
      ov = af && m_out == MAXO && !df;
      ev = ac | (int'(du) << 5) | (int'(ov) << 6);
      if (af && !ov) m_out++;
      if (df && !du) m_out--;
      m_err = ev != 0;
      if (ev != 0) begin
        if (clr) begin
          m_sticky = ev; m_cnt = 1;
        end else begin
          m_sticky |= ev;
          if (m_cnt < CMAX) m_cnt++;
        end
        if (!m_cv || clr) begin
          m_cv = 1; m_ccls = ev;
          if (af && (ac != 0 || ov)) begin
            m_caddr = int'(bus.a_address_i);
            m_csrc  = int'(bus.a_source_i);
            m_cop   = int'(bus.a_opcode_i);
            m_csz   = int'(bus.a_size_i);
          end else begin
            m_caddr = 0; m_csrc = 0; m_cop = 0; m_csz = 0;
          end
        end
      end else if (clr) begin
        m_sticky = 0; m_cnt = 0; m_cv = 0; m_ccls = 0;
        m_caddr = 0; m_csrc = 0; m_cop = 0; m_csz = 0;
      end
    end
  end

  // Compare every cycle; comb check once inputs settle.
  always @(negedge clk) begin
    chk("outstanding", outs, m_out);
    chk("err_o", err, m_err);
    chk("err_class", err_class, m_sticky);
    chk("err_cnt", err_cnt, m_cnt);
    chk("cap_valid", cap_valid, CAP ? m_cv : 0);
    chk("cap_class", cap_class, CAP ? m_ccls : 0);
    chk("cap_addr", cap_addr, CAP ? m_caddr : 0);
    chk("cap_source", cap_source, CAP ? m_csrc : 0);
    chk("cap_opcode", cap_opcode, CAP ? m_cop : 0);
    chk("cap_size", cap_size, CAP ? m_csz : 0);
    #4;
    chk("err_comb", err_comb, bus.a_valid_i &&
        (m_cls(int'(bus.a_opcode_i), int'(bus.a_size_i),
               int'(bus.a_address_i), int'(bus.a_mask_i)) & 31) != 0);
  end

  task automatic set_in(bit av, bit ar, int op, int sz, int addr,
                        int mask, int src, bit dv, bit dr, bit c);
    bus.a_valid_i   = av;
    bus.a_ready_i   = ar;
    bus.a_opcode_i  = 3'(op);
    bus.a_size_i    = SZW'(sz);
    bus.a_address_i = AW'(addr);
    bus.a_mask_i    = 8'(mask);
    bus.a_source_i  = IW'(src);
    bus.d_valid_i   = dv;
    bus.d_ready_i   = dr;
    clr             = c;
  endtask

  task automatic step(bit av, bit ar, int op, int sz, int addr,
                      int mask, int src, bit dv, bit dr, bit c);
    @(negedge clk);
    #2;
    set_in(av, ar, op, sz, addr, mask, src, dv, dr, c);
    @(posedge clk);
    #1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic dstep();
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  initial begin
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    tick();
    chk("rst_cnt", err_cnt, 0);
    chk("rst_outs", outs, 0);
    #1 rst_n = 1'b1;

    // Clean Get, then its response.
    step(1, 1, 4, 3, 'h1000, 'hFF, 1, 0, 0, 0);
    tick();
    chk("get_outs", outs, 1);
    chk("get_noerr", err, 0);
    dstep();
    tick();
    chk("get_drain", outs, 0);

    // PutFull with a lower-half mask in the upper window.
    step(1, 1, 0, 2, 'h1004, 'h0F, 5, 0, 0, 0);
    tick();
    chk("full_err", err, 1);
    chk("full_class", err_class, 'h18);
    chk("full_cnt", err_cnt, 1);
    chk("full_cap_addr", cap_addr, CAP ? 'h1004 : 0);
    chk("full_cap_valid", cap_valid, CAP);
    tick();
    chk("full_pulse_end", err, 0);

    // Oversize Get, first held without ready.
    @(negedge clk);
    #2;
    set_in(1, 0, 4, 4, 'h1003, 'h01, 7, 0, 0, 0);
    #1 chk("size_comb", err_comb, 1);
    @(posedge clk);
    #1 set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 4, 4, 'h1003, 'h01, 7, 0, 0, 0);
    tick();
    chk("size_class", err_class, 'h1A);
    chk("size_cnt", err_cnt, 2);
    chk("size_cap_keep", cap_addr, CAP ? 'h1004 : 0);

    // Drain, then an unexpected response.
    dstep();
    dstep();
    dstep();
    tick();
    chk("dunexp_outs", outs, 0);
    chk("dunexp_class", err_class, 'h3A);
    chk("dunexp_cnt", err_cnt, 3);

    // Five clean fires against a limit of four.
    for (int i = 0; i < 5; i++)
      step(1, 1, 4, 3, 'h2000, 'hFF, 2, 0, 0, 0);
    tick();
    chk("ovf_outs", outs, 4);
    chk("ovf_err", err, 1);
    chk("ovf_class", err_class, 'h7A);
    step(1, 1, 4, 3, 'h2000, 'hFF, 2, 1, 1, 0);
    tick();
    chk("full_ad_outs", outs, 4);
    chk("full_ad_noerr", err, 0);
    for (int i = 0; i < 4; i++) dstep();

    // Clear coinciding with a bad opcode.
    step(1, 1, 7, 3, 'h3000, 'hFF, 9, 0, 0, 1);
    tick();
    chk("clr_ev_class", err_class, 'h01);
    chk("clr_ev_cnt", err_cnt, 1);
    chk("clr_ev_op", cap_opcode, CAP ? 7 : 0);
    chk("clr_ev_outs", outs, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    chk("clr_class", err_class, 0);
    chk("clr_cnt", err_cnt, 0);

    // Back-to-back violations saturate the counter.
    for (int i = 0; i < 17; i++)
      step(1, 1, 7, 3, 'h3000, 'hFF, 9, 1, 1, 0);
    tick();
    chk("sat_cnt", err_cnt, CMAX);
    chk("sat_outs", outs, 1);

    // Reset in the middle of traffic.
    step(1, 1, 4, 3, 'h4000, 'hFF, 3, 0, 0, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_outs", outs, 0);
    chk("mid_rst_cnt", err_cnt, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    tick();
    chk("post_rst_outs", outs, 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/tlul_err_mon.md
# tlul_err_mon

Parametrised TL-UL error monitor for LLKI and other TL-UL slave ports. Checks A-channel legality at any power-of-two data width (32/64/128). Tracks outstanding requests against D-channel responses and classifies each violation. Reports violations as a registered pulse, a sticky class vector, a saturating counter and an optional first-error capture. It sits passively beside a slave's TL-UL port (e.g. next to the LLKI register front end) and never drives the bus.

## Interface
- DW, 64, data width in bits; legal values 32, 64, 128
- AW, 32, address width
- SZW, 3, a_size width
- IW, 8, source ID width
- MaxOutstanding, 4, legal outstanding requests (1..255)
- CW, 16, error counter width
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- a_valid_i / a_ready_i  in  1 / 1  A-channel handshake (observed)
- a_opcode_i  in  3  TL-UL opcode
- a_size_i  in  SZW  log2 bytes
- a_address_i  in  AW  byte address
- a_mask_i  in  DW/8  byte-lane mask
- a_source_i  in  IW  source ID
- d_valid_i / d_ready_i  in  1 / 1  D-channel handshake (observed)
- clr_i  in  1  synchronous clear of sticky state, counter and capture
- err_comb_o  out  1  combinational A-channel violation, qualified by a_valid_i
- err_o  out  1  one-cycle pulse, registered, any violation
- err_class_o  out  7  sticky OR of violation classes
- err_cnt_o  out  CW  saturating count of violating events
- outstanding_o  out  $clog2(MaxOutstanding+1)  current outstanding count
- cap_valid_o  out  1  capture holds the first error since reset/clear
- cap_class_o / cap_addr_o / cap_source_o / cap_opcode_o / cap_size_o  out  7/AW/IW/3/SZW  first-error fields

## Operation
- SubAW = log2(DW/8). Opcodes: PutFullData=0, PutPartialData=1, Get=4.
- Class bits:
  - [0] BAD_OP: opcode not one of the three above.
  - [1] SIZE: a_size > SubAW.
  - [2] ALIGN: address bits [s-1:0] not zero.
  - [3] MASK: mask bits set outside the lane window.
  - [4] FULL: PutFullData whose mask does not cover the whole lane window.
  - [5] D_UNEXP: D handshake while outstanding == 0.
  - [6] OVF: A handshake while outstanding == MaxOutstanding and no D handshake in the same cycle.
- Lane window for size s ≤ SubAW: (2^(2^s) − 1) << (addr[SubAW-1:0] with the low s bits cleared).
- If SIZE is set, ALIGN, MASK and FULL are forced to 0.
- a_fire = a_valid_i & a_ready_i; d_fire = d_valid_i & d_ready_i.
- err_comb_o = a_valid_i & |class[4:0]. It is the unregistered check, for gating only.
- Outstanding counter:
  - +1 on a_fire, −1 on d_fire; both in one cycle leaves it unchanged.
  - Requests that violate classes [4:0] still count, since the slave responds with d_error.
  - Saturates at MaxOutstanding when OVF fires.
  - Stays at 0 when D_UNEXP fires.
- Event in a cycle = (a_fire & |class[4:0]) | D_UNEXP | OVF.
- On an event:
  - err_o pulses next cycle.
  - err_class_o |= event classes.
  - err_cnt_o increments, saturating at 2^CW − 1.
  - Capture loads only if cap_valid_o == 0. D_UNEXP-only events capture class only; the address/source fields hold 0.
- clr_i clears err_class_o, err_cnt_o and the capture, but not outstanding_o. If clr_i coincides with an event, the event wins: class = event classes, cnt = 1, capture loaded.

## Timing
- Reset values: every output is 0 and outstanding = 0.
- err_comb_o: 0-cycle latency.
- All other outputs update 1 cycle after the sampling edge.
- The block is purely observational: no backpressure, and no inputs are modified.
- Back-to-back violating fires produce consecutive err_o pulses, and the counter increments each cycle.
- Reset asserted mid-transaction clears all state immediately; outstanding requests are forgotten.

## Configuration
- TLUL_ERR_CAPTURE_EN defined: capture registers are implemented as described.
- Not defined: cap_* outputs are tied to 0, cap_valid_o is tied to 0, and no capture flops are inferred. All other behaviour is identical.

## Structure
- tlul_pkg holds:
  - opcode constants;
  - the err_class_e bit indices (BAD_OP..OVF);
  - ErrClassW = 7.
- Sub-module tlul_err_lane_chk: purely combinational; parameters DW/SZW/AW; produces class[4:0] from the A fields.
- The top holds the counters, sticky state and capture.
- Elaboration assertions: DW ∈ {32, 64, 128}; MaxOutstanding ≥ 1.

## Test plan
- DW=64, Get, size 3, address 0x1000, mask 0xFF, a_fire → no err_o; outstanding goes 1; d_fire → 0.
- PutFullData, size 2, address 0x1004, mask 0x0F → class FULL and MASK (window 0xF0); err_o pulse at +1 cycle; cnt=1; cap_addr=0x1004.
- Get, size 4 at DW=64 → class SIZE only; ALIGN/MASK/FULL masked; err_comb_o=1 while a_valid_i, even with a_ready_i=0.
- d_fire with outstanding 0 → D_UNEXP, outstanding stays 0; then 5 A fires with MaxOutstanding=4 and no D → OVF on the 5th, outstanding=4.
- Two errors, then clr_i coincident with a BAD_OP (opcode 7) fire → class=0x01, cnt=1, capture=opcode 7.
- Build without TLUL_ERR_CAPTURE_EN and repeat scenario 2 → cap_valid_o=0 and cap_addr_o=0; err/cnt unchanged.
